// File: rtl/ahb_mem_reader.sv
// AHB-Lite read-back master: reads a contiguous run of words, one transfer in flight,
// and streams each returned word out over a valid/ready port.
module ahb_mem_reader #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  word_cnt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready
);

    localparam logic [ADDR_W-1:0] ADDR_STEP     = ADDR_W'(DATA_W / 8);
    localparam logic [1:0]        HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]        HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (word_cnt != '0) begin
                        addr_d  = {base_addr[ADDR_W-1:2], 2'b00};
                        cnt_d   = word_cnt;
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ADDR: begin
                if (hready) state_d = S_DATA;
            end
            S_DATA: begin
                if (hready) begin
                    if (hresp) begin
                        // Error aborts the job; the remaining words are never requested.
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dout_d       = hrdata;
                        dout_valid_d = 1'b1;
                        state_d      = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (dout_ready) begin
                    dout_valid_d = 1'b0;
                    cnt_d        = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_STEP;
                        state_d = S_ADDR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign haddr      = addr_q;
    assign htrans     = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hwrite     = 1'b0;
    assign hsize      = 3'b010;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_ahb_mem_reader.sv
// Directed bench for ahb_mem_reader: behavioural AHB slave with wait/error injection,
// a bus/stream monitor, and hand-computed expectations per job.
module tb_ahb_mem_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_cnt = '0;
    logic        busy, done, err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic [31:0] hrdata = '0;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;

    ahb_mem_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_cnt   (word_cnt),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsize      (hsize),
        .hready     (hready),
        .hresp      (hresp),
        .hrdata     (hrdata),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave configuration and memory image (written by the stimulus only)
    logic [31:0] mem [0:255];
    int          addr_waits = 0;
    int          data_waits = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;

    // Slave and monitor state
    int          ph = 0;
    int          wcnt = 0;
    logic [31:0] dph_addr = '0;
    logic [31:0] addr_log [0:255];
    logic [31:0] out_log [0:255];
    int          addr_n = 0;
    int          out_n = 0;
    int          ns_cnt = 0;
    int          viol = 0;
    logic        prev_ns_wait = 1'b0;
    logic [31:0] prev_haddr = '0;
    logic        prev_out_wait = 1'b0;
    logic [31:0] prev_dout = '0;

    always @(negedge clk) begin
        if (reset) begin
            ph = 0; wcnt = 0; hready = 1'b1; hresp = 1'b0;
            prev_ns_wait = 1'b0; prev_out_wait = 1'b0;
        end else begin
            if (ph == 0) begin
                hresp = 1'b0;
                if (htrans == 2'b10) begin
                    if (wcnt < addr_waits) begin
                        hready = 1'b0; wcnt++;
                    end else begin
                        hready = 1'b1; wcnt = 0; ph = 1; dph_addr = haddr;
                    end
                end else begin
                    hready = 1'b1;
                end
            end else begin
                if (wcnt < data_waits) begin
                    hready = 1'b0; hresp = 1'b0; hrdata = 32'hDEAD_BEEF; wcnt++;
                end else begin
                    hready = 1'b1; wcnt = 0; ph = 0;
                    hrdata = mem[dph_addr[9:2]];
                    hresp  = err_en && (dph_addr == err_addr);
                end
            end
            if (htrans == 2'b10) ns_cnt++;
            if (htrans == 2'b10 && hready) begin
                addr_log[addr_n[7:0]] = haddr; addr_n++;
            end
            if (prev_ns_wait && (htrans != 2'b10 || haddr != prev_haddr)) viol++;
            prev_ns_wait = (htrans == 2'b10) && !hready;
            prev_haddr   = haddr;
            if (prev_out_wait && (!dout_valid || dout != prev_dout)) viol++;
            if (dout_valid && htrans == 2'b10) viol++;
            prev_out_wait = dout_valid && !dout_ready;
            prev_dout     = dout;
            if (dout_valid && dout_ready) begin
                out_log[out_n[7:0]] = dout; out_n++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] c);
        base_addr = b;
        word_cnt  = c;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 1;
        while (!done && cyc < budget) begin
            step();
            cyc++;
        end
        chk("done_seen", done, 1'b1);
    endtask

    initial begin
        int cyc, a0, o0, v0, n0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        mem[64] = 32'h11; mem[65] = 32'h22; mem[66] = 32'h33; mem[67] = 32'h44;

        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_haddr", haddr, 0);
        chk("rst_htrans", htrans, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dvalid", dout_valid, 0);
        chk("hwrite", hwrite, 0);
        chk("hsize", hsize, 3'b010);

        // 1: four words, zero wait states
        a0 = addr_n; o0 = out_n; v0 = viol;
        pulse_start(32'h100, 16'd4);
        chk("t1_busy", busy, 1);
        wait_done(40, cyc);
        chk("t1_cycles", cyc, 13);
        chk("t1_err", err, 0);
        chk("t1_nwords", out_n - o0, 4);
        chk("t1_w0", out_log[o0], 32'h11);
        chk("t1_w1", out_log[o0+1], 32'h22);
        chk("t1_w2", out_log[o0+2], 32'h33);
        chk("t1_w3", out_log[o0+3], 32'h44);
        chk("t1_a0", addr_log[a0], 32'h100);
        chk("t1_a1", addr_log[a0+1], 32'h104);
        chk("t1_a2", addr_log[a0+2], 32'h108);
        chk("t1_a3", addr_log[a0+3], 32'h10C);
        step();
        chk("t1_busy_after", busy, 0);
        chk("t1_done_pulse", done, 0);

        // 2: zero-length job
        n0 = ns_cnt;
        pulse_start(32'h100, 16'd0);
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 1);
        step();
        chk("t2_busy_after", busy, 0);
        chk("t2_done_after", done, 0);
        chk("t2_nonseq", ns_cnt - n0, 0);

        // 3: three wait states on both phases
        addr_waits = 3; data_waits = 3;
        a0 = addr_n; o0 = out_n; v0 = viol; n0 = ns_cnt;
        pulse_start(32'h200, 16'd2);
        wait_done(80, cyc);
        chk("t3_nwords", out_n - o0, 2);
        chk("t3_w0", out_log[o0], 32'hA500_0080);
        chk("t3_w1", out_log[o0+1], 32'hA500_0081);
        chk("t3_a1", addr_log[a0+1], 32'h204);
        chk("t3_nonseq", ns_cnt - n0, 8);
        chk("t3_stable", viol - v0, 0);
        addr_waits = 0; data_waits = 0;
        step();

        // 4: sink stalls 5 cycles in OUT
        o0 = out_n; v0 = viol;
        dout_ready = 1'b0;
        pulse_start(32'h100, 16'd2);
        cyc = 0;
        while (!dout_valid && cyc < 20) begin step(); cyc++; end
        chk("t4_valid_seen", dout_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", dout_valid, 1);
            chk("t4_hold_dout", dout, 32'h11);
            chk("t4_no_nonseq", htrans, 2'b00);
            step();
        end
        dout_ready = 1'b1;
        wait_done(40, cyc);
        chk("t4_nwords", out_n - o0, 2);
        chk("t4_w1", out_log[o0+1], 32'h22);
        chk("t4_proto", viol - v0, 0);
        step();

        // 5: error response on the second word
        a0 = addr_n; o0 = out_n;
        err_en = 1'b1; err_addr = 32'h104;
        pulse_start(32'h100, 16'd4);
        wait_done(40, cyc);
        chk("t5_cycles", cyc, 6);
        chk("t5_err", err, 1);
        chk("t5_nwords", out_n - o0, 1);
        chk("t5_w0", out_log[o0], 32'h11);
        chk("t5_naddr", addr_n - a0, 2);
        err_en = 1'b0;
        step();
        chk("t5_err_sticky", err, 1);

        // 6: address wrap; start also clears err
        a0 = addr_n; o0 = out_n;
        pulse_start(32'hFFFF_FFFC, 16'd2);
        chk("t6_err_clr", err, 0);
        wait_done(40, cyc);
        chk("t6_a0", addr_log[a0], 32'hFFFF_FFFC);
        chk("t6_a1", addr_log[a0+1], 32'h0);
        chk("t6_w0", out_log[o0], 32'hA500_00FF);
        chk("t6_w1", out_log[o0+1], 32'hA500_0000);
        step();

        // Reset while a data phase is outstanding; base low bits are dropped
        a0 = addr_n; o0 = out_n;
        data_waits = 3;
        pulse_start(32'h0000_0103, 16'd3);
        step();
        chk("rm_in_data", htrans, 2'b00);
        chk("rm_busy_pre", busy, 1);
        reset = 1'b1;
        step();
        chk("rm_busy", busy, 0);
        chk("rm_done", done, 0);
        chk("rm_err", err, 0);
        chk("rm_haddr", haddr, 0);
        chk("rm_htrans", htrans, 0);
        chk("rm_dout", dout, 0);
        chk("rm_dvalid", dout_valid, 0);
        reset = 1'b0;
        data_waits = 0;
        step();
        chk("rm_idle", busy, 0);
        chk("rm_addr_align", addr_log[a0], 32'h100);
        chk("rm_nwords", out_n - o0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
